// File: rtl/timer_pkg.sv
// Shared types and defaults for the interval-timer controller.
package timer_pkg;

    localparam int unsigned PRESC_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        TMR_IDLE   = 2'b00,
        TMR_RUN    = 2'b01,
        TMR_PAUSED = 2'b10
    } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: emits a tick every presc+1 enabled cycles.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESC_W = PRESC_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               wrap;

    assign wrap = (cnt_q == presc);
    assign tick = enable && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Interval-timer controller: config capture, run/pause/stop FSM, count and irq.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = PRESC_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_period,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               cfg_periodic,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    output logic [WIDTH-1:0]   count,
    output logic [1:0]         state,
    output logic               busy,
    output logic               irq
);

    tmr_state_e         state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   period_q;
    logic [PRESC_W-1:0] presc_q;
    logic               periodic_q;
    logic               irq_q, irq_d;

    logic               cfg_xfer;
    logic [WIDTH-1:0]   eff_period;
    logic               run_en;
    logic               presc_clear;
    logic               tick;
    logic               terminal;

    assign cfg_ready  = (state_q == TMR_IDLE);
    assign cfg_xfer   = cfg_valid && cfg_ready;
    assign eff_period = cfg_xfer ? cfg_period : period_q;

    // A PAUSED cycle with pause released counts immediately, so a pause
    // held for k edges stretches the interval by exactly k cycles.
    assign run_en      = (state_q != TMR_IDLE) && !stop && !pause;
    assign presc_clear = (state_q == TMR_IDLE) || stop;
    assign terminal    = tick && (count_q == period_q - WIDTH'(1));

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clear  (presc_clear),
        .enable (run_en),
        .presc  (presc_q),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        irq_d   = 1'b0;
        case (state_q)
            TMR_IDLE: begin
                if (start && (eff_period != '0)) begin
                    state_d = TMR_RUN;
                    count_d = '0;
                end
            end
            TMR_RUN, TMR_PAUSED: begin
                if (stop) begin
                    state_d = TMR_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = TMR_PAUSED;
                end else begin
                    state_d = TMR_RUN;
                    if (terminal) begin
                        count_d = '0;
                        irq_d   = 1'b1;
                        if (!periodic_q) begin
                            state_d = TMR_IDLE;
                        end
                    end else if (tick) begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = TMR_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TMR_IDLE;
            count_q    <= '0;
            irq_q      <= 1'b0;
            period_q   <= '0;
            presc_q    <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            irq_q   <= irq_d;
            if (cfg_xfer) begin
                period_q   <= cfg_period;
                presc_q    <= cfg_presc;
                periodic_q <= cfg_periodic;
            end
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign busy  = (state_q != TMR_IDLE);
    assign irq   = irq_q;

endmodule
